// File: rtl/noc_pkg.sv
// Shared NoC constants and the flit type used by the injector and its FIFO.
package noc_pkg;

    localparam int unsigned FLIT_W         = 64;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_FLIT = FLIT_W / BYTE_W;
    localparam int unsigned ASM_W          = (BYTES_PER_FLIT - 1) * BYTE_W;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock flit FIFO; storage, pointers and occupancy all clear on reset.
// The caller guarantees push_i is only raised when there is room.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/flit_injector.sv
// Packs a never-stalling byte stream into 64-bit flits and queues them for a router.
// Full FIFO drops the completed flit; FLIT_INJECTOR_DROP_CNT_EN adds a drop counter.
module flit_injector
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              pack_busy
`ifdef FLIT_INJECTOR_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
    logic             flit_done;
    flit_t            flit_data;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        flit_done  = 1'b0;
        flit_data  = {in_byte, asm_q};
        if (in_valid) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'(BYTES_PER_FLIT - 1)) begin
                flit_done = 1'b1;
            end else begin
                for (int unsigned i = 0; i < BYTES_PER_FLIT - 1; i++) begin
                    if (byte_cnt_q == 3'(i)) begin
                        asm_d[i*BYTE_W +: BYTE_W] = in_byte;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // A full FIFO still takes the flit if the head leaves in the same cycle.
    assign fifo_full = (count == CNT_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push_ok   = flit_done && (!fifo_full || pop);
    assign drop      = flit_done && !push_ok;
    assign pack_busy = (byte_cnt_q != '0);

    sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_ok),
        .wdata_i (flit_data),
        .pop_i   (pop),
        .rdata_o (out_flit),
        .valid_o (out_valid),
        .count_o (count)
    );

`ifdef FLIT_INJECTOR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO flit entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 3, SHALL set the width of the occupancy output and SHALL equal $clog2(DEPTH+1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 in_byte  input  8  SHALL carry traffic-generator byte data.
REQ-006 in_valid  input  1  SHALL qualify in_byte; the source never stalls, and no ready signal exists.
REQ-007 out_flit  output  64  SHALL present the FIFO head flit to the router input.
REQ-008 out_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-009 out_ready  input  1  SHALL be the router's acceptance; a pop occurs when out_valid && out_ready.
REQ-010 count  output  CNT_W  SHALL report the FIFO occupancy, 0..DEPTH.
REQ-011 pack_busy  output  1  SHALL be high while a partial flit is held, i.e. byte_cnt != 0.

Function
REQ-012 Packer SHALL hold a 3-bit byte_cnt and a 56-bit assembly register; each in_valid cycle SHALL write in_byte into byte lane byte_cnt (lane 0 = bits [7:0], LSB first) and increment byte_cnt.
REQ-013 On the 8th byte (byte_cnt==7 && in_valid), packer SHALL form the flit {in_byte, assembly[55:0]} and present it as a push in that same cycle; byte_cnt SHALL wrap to 0.
REQ-014 Push SHALL be accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle; otherwise the flit SHALL be dropped silently, and the packer SHALL continue with the next byte.
REQ-015 Latency: an accepted flit SHALL appear on out_flit/out_valid one cycle after the cycle of its 8th byte, when the FIFO was empty.
REQ-016 FIFO SHALL be first-in first-out; out_flit SHALL equal the head entry; out_flit SHALL be stable while out_valid && !out_ready.
REQ-017 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-018 Simultaneous push and pop at count==0 SHALL NOT occur, because out_valid is low; the push SHALL be accepted and count SHALL become 1.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-020 in_valid low SHALL leave byte_cnt and the assembly register unchanged; gaps between bytes SHALL be tolerated.

Reset
REQ-021 Asserting rst (low) SHALL asynchronously clear byte_cnt, the assembly register, both pointers, count, and all FIFO storage.
REQ-022 While rst is low: out_valid=0, out_flit=64'h0, count=0, pack_busy=0.
REQ-023 Reset mid-flit SHALL discard the partial flit; the first valid byte after reset release SHALL land in lane 0.

Configuration
REQ-024 Macro FLIT_INJECTOR_DROP_CNT_EN defined: the block SHALL add output drop_cnt [15:0], reset 0, incrementing by 1 per dropped flit and saturating at 16'hFFFF.
REQ-025 Macro FLIT_INJECTOR_DROP_CNT_EN undefined: the drop_cnt port and its logic SHALL be absent; drop behaviour is otherwise identical.

Structure
REQ-026 Shared package noc_pkg SHALL hold FLIT_W=64, BYTE_W=8, BYTES_PER_FLIT=8, and the flit typedef (64-bit vector).
REQ-027 FIFO storage and pointers SHALL be a sub-module, sync_fifo (width FLIT_W, depth DEPTH); packer and drop logic SHALL sit in flit_injector.

Verification
REQ-028 Reset, then bytes 8'h01..8'h08 on consecutive cycles with out_ready=0 -> one cycle after byte 8'h08: out_valid=1, out_flit=64'h0807060504030201, count=1.
REQ-029 out_ready=0 and 5 flits packed with DEPTH=4 -> count=4 and the 5th flit is lost; with the macro, drop_cnt=1; then out_ready=1 -> exactly the first 4 flits exit in order.
REQ-030 count=4 with out_ready=1 held and a flit completing in the same cycle -> push accepted, count stays 4, drop_cnt stays 0.
REQ-031 3 bytes sent, rst pulsed low for one cycle, then 8 bytes 8'hA0..8'hA7 -> out_flit=64'hA7A6A5A4A3A2A1A0; pack_busy=0 during reset.
REQ-032 Bytes with in_valid toggling every other cycle -> same flit content as back-to-back input; pack_busy high from byte 1 through byte 7.
REQ-033 Continuous flits with out_ready=1 over 20 flits -> pointers wrap; no loss, no reorder, count ≤ 1 throughout.
